servo_pwm_multi: RTL and testbench



---
 rtl/servo_pwm_multi.sv | 124 ++++++++++++
 tb/tb_servo_pwm_multi.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi: multi-channel servo/ESC PWM generator with a shared frame
// timebase. Each channel's pulse width tracks a clamped per-channel target and
// is slew-limited once per frame at the frame boundary.
module servo_pwm_multi #(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned CNT_W     = 21,
  parameter int unsigned PERIOD    = 2000000,
  parameter int unsigned PW_MIN    = 100000,
  parameter int unsigned PW_MID    = 150000,
  parameter int unsigned PW_MAX    = 200000,
  parameter int unsigned RAMP_STEP = 5000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH*CNT_W-1:0] target,
  output logic [CNT_W-1:0]        count,
  output logic                    frame_tick,
  output logic [NUM_CH*CNT_W-1:0] width,
  output logic [NUM_CH-1:0]       settled,
  output logic [NUM_CH-1:0]       pwm
);

  localparam int unsigned D_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] LAST_V = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] MIN_V  = CNT_W'(PW_MIN);
  localparam logic [CNT_W-1:0] MID_V  = CNT_W'(PW_MID);
  localparam logic [CNT_W-1:0] MAX_V  = CNT_W'(PW_MAX);
  localparam logic [CNT_W-1:0] STEP_V = CNT_W'(RAMP_STEP);
  localparam logic signed [D_W-1:0] STEP_S = D_W'(RAMP_STEP);

  // Reject illegal parameter sets at elaboration
  if (!(PW_MIN <= PW_MID && PW_MID <= PW_MAX && PW_MAX < PERIOD &&
        64'(PERIOD) <= (64'd1 << CNT_W))) begin : g_param_check
    $error("servo_pwm_multi: illegal parameter set");
  end

  // ST_IDLE holds the counter at 0 for the first cycle after reset so the
  // first visible frame starts with count==0 and a full pulse.
  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          eff [NUM_CH];
  logic [CNT_W-1:0]          tgt;
  logic [CNT_W-1:0]          cur_w;
  logic signed [D_W-1:0]     diff;
  logic [CNT_W-1:0]          count_d;
  logic                      boundary;
  logic [NUM_CH*CNT_W-1:0]   width_d;
  logic [NUM_CH-1:0]         pwm_d;
  logic [NUM_CH-1:0]         settled_d;

  // Effective target: neutral when disabled, otherwise clamped to legal range
  always_comb begin
    tgt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      tgt    = target[i*CNT_W +: CNT_W];
      eff[i] = MID_V;
      if (enable[i]) begin
        if (tgt < MIN_V)      eff[i] = MIN_V;
        else if (tgt > MAX_V) eff[i] = MAX_V;
        else                  eff[i] = tgt;
      end
    end
  end

  // Next state: counter, boundary slew update, and look-ahead pwm/settled
  always_comb begin
    state_d   = ST_RUN;
    count_d   = '0;
    boundary  = 1'b0;
    width_d   = width;
    pwm_d     = '0;
    settled_d = '0;
    cur_w     = '0;
    diff      = '0;
    case (state_q)
      ST_IDLE: count_d = '0;
      ST_RUN: begin
        if (count == LAST_V) boundary = 1'b1;
        else                 count_d  = count + CNT_W'(1);
      end
      default: count_d = '0;
    endcase
    for (int i = 0; i < NUM_CH; i++) begin
      cur_w = width[i*CNT_W +: CNT_W];
      diff  = $signed({1'b0, eff[i]}) - $signed({1'b0, cur_w});
      if (boundary) begin
        if (RAMP_STEP == 0 || (diff <= STEP_S && diff >= -STEP_S))
          width_d[i*CNT_W +: CNT_W] = eff[i];
        else if (diff > 0)
          width_d[i*CNT_W +: CNT_W] = cur_w + STEP_V;
        else
          width_d[i*CNT_W +: CNT_W] = cur_w - STEP_V;
      end
      pwm_d[i]     = count_d < width_d[i*CNT_W +: CNT_W];
      settled_d[i] = width_d[i*CNT_W +: CNT_W] == eff[i];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      frame_tick <= 1'b0;
      width      <= {NUM_CH{MID_V}};
      pwm        <= '0;
      settled    <= '0;
    end else begin
      count      <= count_d;
      frame_tick <= (count_d == '0);
      width      <= width_d;
      pwm        <= pwm_d;
      settled    <= settled_d;
    end
  end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Bench for servo_pwm_multi: two instances (slewed and unslewed) on shortened
// timing, checked every cycle against a frame-level arithmetic model plus
// hand-computed literal expectations.
module tb_servo_pwm_multi;

  localparam int unsigned NCH  = 2;
  localparam int unsigned CW   = 10;
  localparam int unsigned PER  = 500;
  localparam int unsigned PMIN = 100;
  localparam int unsigned PMID = 150;
  localparam int unsigned PMAX = 200;
  localparam int unsigned STEP = 10;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NCH-1:0]    enable = '0;
  logic [NCH*CW-1:0] target = '0;

  logic [CW-1:0]     count_a, count_b;
  logic              ft_a, ft_b;
  logic [NCH*CW-1:0] width_a, width_b;
  logic [NCH-1:0]    settled_a, settled_b;
  logic [NCH-1:0]    pwm_a, pwm_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  servo_pwm_multi #(.NUM_CH(NCH), .CNT_W(CW), .PERIOD(PER), .PW_MIN(PMIN),
    .PW_MID(PMID), .PW_MAX(PMAX), .RAMP_STEP(STEP)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .target(target),
    .count(count_a), .frame_tick(ft_a), .width(width_a),
    .settled(settled_a), .pwm(pwm_a));

  servo_pwm_multi #(.NUM_CH(NCH), .CNT_W(CW), .PERIOD(PER), .PW_MIN(PMIN),
    .PW_MID(PMID), .PW_MAX(PMAX), .RAMP_STEP(0)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .target(target),
    .count(count_b), .frame_tick(ft_b), .width(width_b),
    .settled(settled_b), .pwm(pwm_b));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          rs [2] = '{STEP, 0};
  int          m_w [2][NCH];
  int          m_t;
  bit          m_known = 1'b0;
  bit          m_started;
  int          e_cnt;
  bit          e_ft;
  bit [NCH-1:0] e_pwm [2];
  bit [NCH-1:0] e_set [2];

  function automatic int eff_of(input int ch);
    int t;
    if (!enable[ch]) return PMID;
    t = int'(target[ch*CW +: CW]);
    if (t < PMIN) return PMIN;
    if (t > PMAX) return PMAX;
    return t;
  endfunction

  // Model advances on each rising edge; m_t counts cycles since reset release
  always @(posedge clk) begin
    if (reset) begin
      m_known = 1'b1;
      m_started = 1'b0;
      m_t = 0;
      for (int k = 0; k < 2; k++) begin
        for (int c = 0; c < NCH; c++) m_w[k][c] = PMID;
        e_pwm[k] = '0;
        e_set[k] = '0;
      end
      e_cnt = 0;
      e_ft = 1'b0;
    end else if (m_known) begin
      if (!m_started) begin
        m_started = 1'b1;
        m_t = 0;
      end else begin
        m_t++;
        if (m_t % PER == 0) begin
          for (int k = 0; k < 2; k++)
            for (int c = 0; c < NCH; c++) begin
              int d;
              d = eff_of(c) - m_w[k][c];
              if (rs[k] == 0 || (d <= rs[k] && d >= -rs[k])) m_w[k][c] = eff_of(c);
              else if (d > 0) m_w[k][c] += rs[k];
              else m_w[k][c] -= rs[k];
            end
        end
      end
      e_cnt = m_t % PER;
      e_ft = (e_cnt == 0);
      for (int k = 0; k < 2; k++)
        for (int c = 0; c < NCH; c++) begin
          e_pwm[k][c] = (e_cnt < m_w[k][c]);
          e_set[k][c] = (m_w[k][c] == eff_of(c));
        end
    end
  end

  task automatic cmp_inst(input string nm, input int k, input logic [CW-1:0] cnt,
                          input logic ft, input logic [NCH*CW-1:0] wid,
                          input logic [NCH-1:0] st, input logic [NCH-1:0] pw);
    chk({nm, ".count"}, int'(cnt), e_cnt);
    chk({nm, ".frame_tick"}, int'(ft), int'(e_ft));
    chk({nm, ".pwm"}, int'(pw), int'(e_pwm[k]));
    chk({nm, ".settled"}, int'(st), int'(e_set[k]));
    for (int c = 0; c < NCH; c++)
      chk($sformatf("%s.width%0d", nm, c), int'(wid[c*CW +: CW]), m_w[k][c]);
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (m_known) begin
      cmp_inst("a", 0, count_a, ft_a, width_a, settled_a, pwm_a);
      cmp_inst("b", 1, count_b, ft_b, width_b, settled_b, pwm_b);
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic goto_count(input int c);
    for (int i = 0; i < int'(PER) + 2 && int'(count_a) != c; i++) cyc(1);
    chk("sync_count", int'(count_a), c);
  endtask

  task automatic pulse_len(input string nm, input logic sel_b, input int exp);
    int hi;
    hi = 0;
    for (int i = 0; i < int'(PER); i++) begin
      if (sel_b ? pwm_b[0] : pwm_a[0]) hi++;
      cyc(1);
    end
    chk(nm, hi, exp);
  endtask

  initial begin
    reset = 1'b1;
    cyc(3);
    chk("rst_count", int'(count_a), 0);
    chk("rst_pwm", int'(pwm_a), 0);
    chk("rst_width", int'(width_a), (PMID << CW) | PMID);
    reset = 1'b0;
    cyc(1);
    chk("rel_count", int'(count_a), 0);
    chk("rel_tick", int'(ft_a), 1);
    chk("rel_pwm", int'(pwm_a), 3);
    pulse_len("pulse_mid", 1'b0, 150);
    chk("wrap_count", int'(count_a), 0);
    chk("wrap_tick", int'(ft_a), 1);

    // Ramp ch0 up, ch1 down into the lower clamp
    enable = 2'b11;
    target = {CW'(20), CW'(200)};
    cyc(4 * PER);
    chk("ramp_a_w0", int'(width_a[0 +: CW]), 190);
    chk("ramp_a_w1", int'(width_a[CW +: CW]), 110);
    chk("ramp_a_settled", int'(settled_a), 0);
    chk("step0_b_w0", int'(width_b[0 +: CW]), 200);
    chk("step0_b_w1", int'(width_b[CW +: CW]), 100);
    cyc(PER);
    chk("ramp_done_w0", int'(width_a[0 +: CW]), 200);
    chk("ramp_done_w1", int'(width_a[CW +: CW]), 100);
    chk("ramp_done_settled", int'(settled_a), 3);
    pulse_len("pulse_max", 1'b0, 200);

    // Upper clamp, then disable returns to neutral
    target = {CW'(1000), CW'(200)};
    cyc(11 * PER);
    chk("clamp_hi_w1", int'(width_a[CW +: CW]), 200);
    enable = 2'b01;
    cyc(4 * PER);
    chk("dis_w1_mid", int'(width_a[CW +: CW]), 160);
    cyc(PER);
    chk("dis_w1_done", int'(width_a[CW +: CW]), 150);

    // Mid-frame reset aborts the pulse
    goto_count(120);
    reset = 1'b1;
    cyc(1);
    chk("mrst_count", int'(count_a), 0);
    chk("mrst_pwm", int'(pwm_a), 0);
    chk("mrst_w0", int'(width_a[0 +: CW]), 150);
    reset = 1'b0;
    cyc(1);
    pulse_len("mrst_pulse", 1'b0, 150);

    // Glitch at PERIOD-2 reverted at PERIOD-1; ch1 changes on the boundary cycle
    goto_count(PER - 2);
    target[0 +: CW] = CW'(100);
    cyc(1);
    target[0 +: CW] = CW'(200);
    enable = 2'b11;
    target[CW +: CW] = CW'(180);
    cyc(1);
    chk("glitch_b_w0", int'(width_b[0 +: CW]), 200);
    chk("same_edge_b_w1", int'(width_b[CW +: CW]), 180);
    chk("same_edge_a_w1", int'(width_a[CW +: CW]), 160);

    // Unslewed instance: mid-frame change applies only at the wrap
    goto_count(250);
    target[0 +: CW] = CW'(180);
    cyc(50);
    chk("hold_b_w0", int'(width_b[0 +: CW]), 200);
    goto_count(0);
    chk("apply_b_w0", int'(width_b[0 +: CW]), 180);
    pulse_len("pulse_b_180", 1'b1, 180);

    // Randomized phase: targets, enables, occasional resets
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(0, 49) == 0) target[0 +: CW] = CW'($urandom_range(0, 1023));
      if ($urandom_range(0, 49) == 0) target[CW +: CW] = CW'($urandom_range(0, 1023));
      if ($urandom_range(0, 199) == 0) enable = NCH'($urandom_range(0, 3));
      reset = ($urandom_range(0, 2999) == 0);
      cyc(1);
    end
    reset = 1'b0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
